mult: RTL and testbench
=======================

Name: mult

Overview:
- Start-triggered 8-bit Fibonacci LFSR stepper for the LFSR project.
- On a start request it loads a fixed seed, then clocks the LFSR a programmable number of steps (`select`) using a programmable tap mask (`taps`).
- It exposes the register state on `prod` and holds `busy` high while stepping.
- Sits between control logic (issues start, waits on busy) and any consumer of pseudo-random bytes.

Parameters:
- WIDTH, 8: LFSR / data width. `select`, `taps` and `prod` are WIDTH bits wide.
- SEED, 8'h01: value loaded into the LFSR at the start of every run. Must be non-zero.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  run request, rising-edge detected.
- select  input  WIDTH  number of LFSR steps to perform, sampled at accept.
- taps  input  WIDTH  feedback tap mask, sampled at accept.
- prod  output  WIDTH  current LFSR state, registered.
- busy  output  1  high while a run is in progress, registered.

Behaviour:
- Clock and reset:
  - Single clock `clk`; reset is synchronous and active-low on `rst_n`.
  - All state updates occur on the rising edge of `clk`.
- Reset (rst_n=0 at a rising edge):
  - prod=0, busy=0, step counter=0, latched taps=0, start_d=0.
  - Reset takes priority over everything, including mid-run; a run in progress is aborted.
- Start detection:
  - start_d is a register tracking start every cycle.
  - A request is a cycle with start=1 and start_d=0 (rising edge).
- States:
  - IDLE (busy=0) and RUN (busy=1). No other states.
- IDLE:
  - On a request: state<=SEED, cnt<=select, tap_reg<=taps, busy<=1, go to RUN.
  - Without a request: prod and busy hold.
- RUN, each cycle:
  - If cnt==0: busy<=0, go to IDLE; prod holds its final value.
  - Else:
    - fb = XOR-reduce(state & tap_reg).
    - state <= {state[WIDTH-2:0], fb}.
    - cnt <= cnt-1.
- Timing:
  - busy is high for exactly select+1 cycles.
  - prod shows SEED in the first busy cycle and one new state per subsequent cycle.
  - Final state after `select` steps is held after busy falls, until the next run or reset.
- Requests while busy:
  - Ignored (no restart, no queuing).
  - start_d still tracks start, so a start held high through the end of a run does not retrigger; a fresh 0->1 transition is required.
- Input stability:
  - `select` and `taps` changes during RUN have no effect (latched at accept).
- Boundary conditions:
  - select=0: one busy cycle, prod=SEED.
  - taps=0: fb is always 0; zeros shift in.
  - If the state reaches 0 it stays 0 for the rest of the run (no lockup escape).
  - Seed is reloaded on every run; prior state is not carried over.
- prod is driven only from a register (no combinational path from inputs).

Test Plan:
- Reset: rst_n=0 for 2 cycles -> prod=8'h00, busy=0; with rst_n=1 and no start edge, outputs hold.
- select=8'h08, taps=8'h09, start 0->1:
  - busy high 9 cycles.
  - prod per cycle 01,03,07,0F,1E,3D,7A,F5,EB.
  - busy falls, prod holds EB.
- select=8'h00, start edge -> busy high 1 cycle, prod=01 afterwards.
- taps=8'h00, select=8'h03 -> prod 01,02,04,08; final 08.
- Start held high across a full run, plus extra start pulses during busy -> exactly one run.
  - A new 0->1 edge after busy=0 starts a second run that reloads 01.
- Reset mid-run (select=8'h08, taps=8'h09, rst_n=0 on 4th busy cycle) -> next cycle prod=00, busy=0; a later start edge runs normally from 01.

Source files
------------

// File: rtl/mult.sv
// Start-triggered Fibonacci LFSR stepper.
// A rising edge on start loads SEED, then the register is clocked `select`
// times with the tap mask latched at accept. busy stays high for select+1
// cycles and prod holds the final state afterwards.
module mult #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] select,
    input  logic [WIDTH-1:0] taps,
    output logic [WIDTH-1:0] prod,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q,  lfsr_d;
    logic [WIDTH-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] tap_q,   tap_d;
    logic             busy_q,  busy_d;
    logic             start_q;

    logic             request;
    logic             fb;

    // A run request is a 0->1 transition of start; start_q follows start even
    // while busy, so a level held through the end of a run cannot retrigger.
    assign request = start && !start_q;

    // Feedback bit: parity of the state bits selected by the latched tap mask.
    assign fb = ^(lfsr_q & tap_q);

    // Next-state and datapath: load on accept, shift while steps remain.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        tap_d   = tap_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (request) begin
                    lfsr_d  = SEED;
                    cnt_d   = select;
                    tap_d   = taps;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    lfsr_d = {lfsr_q[WIDTH-2:0], fb};
                    cnt_d  = cnt_q - 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= '0;
            cnt_q   <= '0;
            tap_q   <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            tap_q   <= tap_d;
            busy_q  <= busy_d;
            start_q <= start;
        end
    end

    assign prod = lfsr_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mult.sv
// Directed bench for the mult LFSR stepper: a vector table of complete runs
// plus hand-written sequences for held start, mid-run reset and input changes.
module tb_mult;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] select;
    logic [7:0] taps;
    logic [7:0] prod;
    logic       busy;

    int errors = 0;
    int checks = 0;

    mult #(.WIDTH(8), .SEED(8'h01)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .select (select),
        .taps   (taps),
        .prod   (prod),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sel;
        logic [7:0] tp;
        logic [7:0] fin;
        int         cycles;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end else begin
            $display("ok   %s: %0h", name, actual);
        end
    endtask

    // Issue a start edge, follow the run to its end; returns busy cycle count.
    task automatic do_run(input logic [7:0] s, input logic [7:0] t, output int n);
        select = s;
        taps   = t;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            n++;
            tick();
        end
    endtask

    logic [7:0] seq09[9];
    int n;

    initial begin
        vecs[0] = '{sel: 8'h08, tp: 8'h09, fin: 8'hEB, cycles: 9};
        vecs[1] = '{sel: 8'h00, tp: 8'h09, fin: 8'h01, cycles: 1};
        vecs[2] = '{sel: 8'h03, tp: 8'h00, fin: 8'h08, cycles: 4};
        vecs[3] = '{sel: 8'h02, tp: 8'h09, fin: 8'h07, cycles: 3};
        vecs[4] = '{sel: 8'h04, tp: 8'h80, fin: 8'h10, cycles: 5};
        vecs[5] = '{sel: 8'h09, tp: 8'h00, fin: 8'h00, cycles: 10};
        seq09 = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3D, 8'h7A, 8'hF5, 8'hEB};

        rst_n = 1'b0; start = 1'b0; select = 8'h00; taps = 8'h00;
        tick(); tick();
        check("reset prod", prod, 8'h00);
        check("reset busy", busy, 0);
        rst_n = 1'b1;
        tick(); tick();
        check("idle hold prod", prod, 8'h00);
        check("idle hold busy", busy, 0);

        // Table-driven complete runs.
        for (int i = 0; i < 6; i++) begin
            do_run(vecs[i].sel, vecs[i].tp, n);
            check($sformatf("vec%0d busy cycles", i), n, vecs[i].cycles);
            check($sformatf("vec%0d final prod", i), prod, vecs[i].fin);
            tick();
            check($sformatf("vec%0d prod held", i), prod, vecs[i].fin);
        end

        // Per-cycle sequence for select=8, taps=09.
        select = 8'h08; taps = 8'h09; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            check($sformatf("seq09 busy[%0d]", k), busy, 1);
            check($sformatf("seq09 prod[%0d]", k), prod, seq09[k]);
            // Changing inputs mid-run must not matter.
            select = 8'hFF; taps = 8'h00;
            tick();
        end
        check("seq09 busy fell", busy, 0);
        check("seq09 final", prod, 8'hEB);

        // Start held high across the run with extra pulses while busy.
        tick();
        select = 8'h08; taps = 8'h09; start = 1'b1;
        tick();
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            n++;
            if (n < 5) start = ~start;
            else start = 1'b1;
            tick();
        end
        check("held start busy cycles", n, 9);
        check("held start final", prod, 8'hEB);
        for (int k = 0; k < 4; k++) tick();
        check("held start no retrigger busy", busy, 0);
        check("held start no retrigger prod", prod, 8'hEB);
        start = 1'b0;
        tick();
        select = 8'h01; taps = 8'h09; start = 1'b1;
        tick();
        start = 1'b0;
        check("second run busy", busy, 1);
        check("second run reload", prod, 8'h01);
        tick(); tick();
        check("second run final", prod, 8'h03);
        check("second run done", busy, 0);

        // Reset on the 4th busy cycle aborts the run.
        select = 8'h08; taps = 8'h09; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("pre-reset busy", busy, 1);
        check("pre-reset prod", prod, 8'h0F);
        rst_n = 1'b0;
        tick();
        check("mid-run reset prod", prod, 8'h00);
        check("mid-run reset busy", busy, 0);
        rst_n = 1'b1;
        tick();
        check("post-reset idle", busy, 0);
        do_run(8'h08, 8'h09, n);
        check("post-reset busy cycles", n, 9);
        check("post-reset final", prod, 8'hEB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
